// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
//   - SZ_*  : store size codes carried on dmem_inchoice
//   - LD_*  : load type codes carried on dmem_outchoice
//   - dmem_state_t : responder FSM states
//   - DMEM_BASE_ADDR / IMEM_BASE_ADDR : default data and instruction segment bases
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0040_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD,
        ST_WR,
        ST_RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the CPU data port and the
// data-memory responder.
//   master (CPU)      : drives req_valid, req_we, dmem_inchoice, dmem_outchoice, addr, data_in
//   slave (responder) : drives req_ready, resp_valid, data_out, resp_err
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  dmem_inchoice;
    logic [2:0]  dmem_outchoice;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        resp_valid;
    logic [31:0] data_out;
    logic        resp_err;

    modport master (
        output req_valid, req_we, dmem_inchoice, dmem_outchoice, addr, data_in,
        input  req_ready, resp_valid, data_out, resp_err
    );

    modport slave (
        input  req_valid, req_we, dmem_inchoice, dmem_outchoice, addr, data_in,
        output req_ready, resp_valid, data_out, resp_err
    );

endinterface

// File: rtl/dmem_word_ram.sv
// dmem_word_ram: single-port DEPTH_WORDS x 32 array, synchronous read and write.
//   clk_in : clock
//   we     : write enable for the addressed word
//   addr   : word index
//   wdata  : word to write
//   rdata  : registered read data (old contents when reading and writing the same word)
module dmem_word_ram #(
    parameter int DEPTH_WORDS = 2048,
    parameter int ADDR_W      = 11
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data port.
//   clk_in, reset : clock and synchronous active-high reset
//   bus (slave)   : valid/ready request with load/store fields, one-cycle response
//                   strobe carrying the load result and an error flag
// Requests walk IDLE -> WAIT -> RD -> (WR) -> RESP. Stores merge into the old word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          WAIT_STATES = 0
) (
    input logic             clk_in,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_t    state;
    logic [3:0]     wait_cnt;
    logic           ready_q;
    logic           resp_valid_q;
    logic           resp_err_q;
    logic [31:0]    data_out_q;

    logic           cap_we;
    logic [1:0]     cap_size;
    logic [2:0]     cap_ld;
    logic [1:0]     cap_lane;
    logic [AW-1:0]  cap_idx;
    logic [31:0]    cap_data;

    logic [31:0]    req_offset;
    logic [1:0]     req_size;
    logic           bad_code;
    logic           req_err;
    logic           accept;

    logic [AW-1:0]  ram_addr;
    logic [31:0]    ram_rdata;
    logic [31:0]    merged;
    logic [31:0]    load_data;
    logic [15:0]    half_v;
    logic [7:0]     byte_v;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.data_out   = data_out_q;

    assign accept     = (state == ST_IDLE) && ready_q && bus.req_valid;
    assign req_offset = bus.addr - BASE_ADDR;

    // Map the request onto an access width; unknown size/type codes are errors.
    always_comb begin
        req_size = SZ_WORD;
        bad_code = 1'b0;
        if (bus.req_we) begin
            case (bus.dmem_inchoice)
                SZ_WORD, SZ_HALF, SZ_BYTE: req_size = bus.dmem_inchoice;
                default:                   bad_code = 1'b1;
            endcase
        end else begin
            case (bus.dmem_outchoice)
                LD_LW:         req_size = SZ_WORD;
                LD_LH, LD_LHU: req_size = SZ_HALF;
                LD_LB, LD_LBU: req_size = SZ_BYTE;
                default:       bad_code = 1'b1;
            endcase
        end
    end

    // Addresses below the base wrap to a huge offset, so the span test catches them too.
    assign req_err = bad_code
                   || (bus.addr < BASE_ADDR)
                   || (req_offset >= SPAN)
                   || ((req_size == SZ_WORD) && (bus.addr[1:0] != 2'b00))
                   || ((req_size == SZ_HALF) && bus.addr[0]);

    // The array read is launched on the edge that leaves IDLE or WAIT, so the word is
    // already present during RD and the response can be registered on RD's exit edge.
    assign ram_addr = (state == ST_IDLE) ? req_offset[AW+1:2] : cap_idx;

    dmem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_ram (
        .clk_in (clk_in),
        .we     (state == ST_WR),
        .addr   (ram_addr),
        .wdata  (merged),
        .rdata  (ram_rdata)
    );

    // Store merge: replace only the addressed lane of the old word.
    always_comb begin
        merged = ram_rdata;
        case (cap_size)
            SZ_HALF: begin
                if (cap_lane[1]) merged[31:16] = cap_data[15:0];
                else             merged[15:0]  = cap_data[15:0];
            end
            SZ_BYTE: merged[{cap_lane, 3'b000} +: 8] = cap_data[7:0];
            default: merged = cap_data;
        endcase
    end

    // Load extract with sign or zero extension.
    always_comb begin
        half_v    = cap_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        byte_v    = ram_rdata[{cap_lane, 3'b000} +: 8];
        load_data = ram_rdata;
        case (cap_ld)
            LD_LH:   load_data = {{16{half_v[15]}}, half_v};
            LD_LHU:  load_data = {16'h0000, half_v};
            LD_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  load_data = {24'h000000, byte_v};
            default: load_data = ram_rdata;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            data_out_q   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q  <= 1'b0;
                        cap_we   <= bus.req_we;
                        cap_size <= req_size;
                        cap_ld   <= bus.dmem_outchoice;
                        cap_lane <= bus.addr[1:0];
                        cap_idx  <= req_offset[AW+1:2];
                        cap_data <= bus.data_in;
                        if (req_err) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            data_out_q   <= 32'h0;
                        end else if (WAIT_STATES == 0) begin
                            state <= ST_RD;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'd0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) state <= ST_RD;
                    else                       wait_cnt <= wait_cnt + 4'd1;
                end
                ST_RD: begin
                    if (cap_we) begin
                        state <= ST_WR;
                    end else begin
                        state        <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        data_out_q   <= load_data;
                    end
                end
                ST_WR: begin
                    state        <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    data_out_q   <= 32'h0;
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    data_out_q   <= 32'h0;
                    ready_q      <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
// dut0 runs with no wait states, dut3 with three; both share clock and reset.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk_in = ~clk_in;

    dmem_responder_if bus0 ();
    dmem_responder_if bus3 ();

    dmem_responder #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(2048), .WAIT_STATES(0)) dut0 (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus0)
    );

    dmem_responder #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(2048), .WAIT_STATES(3)) dut3 (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus3)
    );

    // Issue one request on bus0; lat is the cycle (acceptance edge = 0) with resp_valid high.
    task automatic req0(input logic we, input logic [1:0] inch, input logic [2:0] outch,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] dout, output logic err);
        int guard;
        lat = 0; dout = 32'h0; err = 1'b0;
        @(negedge clk_in);
        bus0.req_valid = 1'b1; bus0.req_we = we; bus0.dmem_inchoice = inch;
        bus0.dmem_outchoice = outch; bus0.addr = a; bus0.data_in = d;
        guard = 0;
        while (bus0.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        if (guard >= 50) begin
            total++; bad++;
            $display("[TB] FAIL req0_accept_timeout got=ready_low want=ready_high addr=%h", a);
            bus0.req_valid = 1'b0;
            return;
        end
        @(posedge clk_in);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_in);
            if (k == 1) bus0.req_valid = 1'b0;
            if (bus0.resp_valid === 1'b1) begin
                lat = k; dout = bus0.data_out; err = bus0.resp_err;
                break;
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("[TB] FAIL req0_resp_timeout got=no_resp want=resp addr=%h", a);
        end
    endtask

    task automatic req3(input logic we, input logic [1:0] inch, input logic [2:0] outch,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] dout, output logic err);
        int guard;
        lat = 0; dout = 32'h0; err = 1'b0;
        @(negedge clk_in);
        bus3.req_valid = 1'b1; bus3.req_we = we; bus3.dmem_inchoice = inch;
        bus3.dmem_outchoice = outch; bus3.addr = a; bus3.data_in = d;
        guard = 0;
        while (bus3.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        if (guard >= 50) begin
            total++; bad++;
            $display("[TB] FAIL req3_accept_timeout got=ready_low want=ready_high addr=%h", a);
            bus3.req_valid = 1'b0;
            return;
        end
        @(posedge clk_in);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_in);
            if (k == 1) bus3.req_valid = 1'b0;
            if (bus3.resp_valid === 1'b1) begin
                lat = k; dout = bus3.data_out; err = bus3.resp_err;
                break;
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("[TB] FAIL req3_resp_timeout got=no_resp want=resp addr=%h", a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        total++; if (bus0.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready0 got=%b want=0", bus0.req_ready); end
        total++; if (bus3.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready3 got=%b want=0", bus3.req_ready); end
        total++; if (bus0.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_valid got=%b want=0", bus0.resp_valid); end
        total++; if (bus0.data_out !== 32'h0) begin bad++; $display("[TB] FAIL rst_data_out got=%h want=00000000", bus0.data_out); end
        total++; if (bus0.resp_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_err got=%b want=0", bus0.resp_err); end
        reset = 1'b0;
        @(negedge clk_in);
        total++; if (bus0.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready0 got=%b want=1", bus0.req_ready); end
        total++; if (bus3.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready3 got=%b want=1", bus3.req_ready); end
    endtask

    task automatic test_word();
        int lat; logic [31:0] dout; logic err;
        req0(1'b1, SZ_WORD, LD_LW, 32'h1001_0004, 32'hDEAD_BEEF, lat, dout, err);
        total++; if (lat !== 3) begin bad++; $display("[TB] FAIL sw_latency got=%0d want=3", lat); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL sw_err got=%b want=0", err); end
        req0(1'b0, SZ_WORD, LD_LW, 32'h1001_0004, 32'h0, lat, dout, err);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL lw_latency got=%0d want=2", lat); end
        total++; if (dout !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL lw_data got=%h want=deadbeef", dout); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL lw_err got=%b want=0", err); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] dout; logic err;
        req0(1'b1, SZ_WORD, LD_LW, 32'h1001_0008, 32'h1122_3344, lat, dout, err);
        req0(1'b1, SZ_BYTE, LD_LW, 32'h1001_000A, 32'h5566_77AA, lat, dout, err);
        total++; if (lat !== 3 || err !== 1'b0) begin bad++; $display("[TB] FAIL sb_resp got=lat%0d_err%b want=lat3_err0", lat, err); end
        req0(1'b0, SZ_WORD, LD_LW, 32'h1001_0008, 32'h0, lat, dout, err);
        total++; if (dout !== 32'h11AA_3344) begin bad++; $display("[TB] FAIL sb_merge got=%h want=11aa3344", dout); end
        req0(1'b0, SZ_WORD, LD_LB, 32'h1001_000A, 32'h0, lat, dout, err);
        total++; if (dout !== 32'hFFFF_FFAA) begin bad++; $display("[TB] FAIL lb_sign got=%h want=ffffffaa", dout); end
        req0(1'b0, SZ_WORD, LD_LBU, 32'h1001_000A, 32'h0, lat, dout, err);
        total++; if (dout !== 32'h0000_00AA) begin bad++; $display("[TB] FAIL lbu_zero got=%h want=000000aa", dout); end
    endtask

    task automatic test_half_lanes();
        int lat; logic [31:0] dout; logic err;
        req0(1'b1, SZ_WORD, LD_LW, 32'h1001_0010, 32'h8001_7FFF, lat, dout, err);
        req0(1'b0, SZ_WORD, LD_LH, 32'h1001_0012, 32'h0, lat, dout, err);
        total++; if (dout !== 32'hFFFF_8001) begin bad++; $display("[TB] FAIL lh_upper got=%h want=ffff8001", dout); end
        req0(1'b0, SZ_WORD, LD_LHU, 32'h1001_0012, 32'h0, lat, dout, err);
        total++; if (dout !== 32'h0000_8001) begin bad++; $display("[TB] FAIL lhu_upper got=%h want=00008001", dout); end
        req0(1'b0, SZ_WORD, LD_LH, 32'h1001_0010, 32'h0, lat, dout, err);
        total++; if (dout !== 32'h0000_7FFF) begin bad++; $display("[TB] FAIL lh_lower got=%h want=00007fff", dout); end
        req0(1'b1, SZ_HALF, LD_LW, 32'h1001_0012, 32'hCAFE_1234, lat, dout, err);
        req0(1'b0, SZ_WORD, LD_LW, 32'h1001_0010, 32'h0, lat, dout, err);
        total++; if (dout !== 32'h1234_7FFF) begin bad++; $display("[TB] FAIL sh_merge got=%h want=12347fff", dout); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] dout; logic err;
        logic [31:0] e_addr [7];
        logic        e_we   [7];
        logic [1:0]  e_in   [7];
        logic [2:0]  e_out  [7];
        e_addr[0] = 32'h1001_0002; e_we[0] = 1'b0; e_in[0] = SZ_WORD; e_out[0] = LD_LW;
        e_addr[1] = 32'h1001_0001; e_we[1] = 1'b1; e_in[1] = SZ_HALF; e_out[1] = LD_LW;
        e_addr[2] = 32'h1000_FFFC; e_we[2] = 1'b0; e_in[2] = SZ_WORD; e_out[2] = LD_LW;
        e_addr[3] = 32'h1001_2000; e_we[3] = 1'b0; e_in[3] = SZ_WORD; e_out[3] = LD_LW;
        e_addr[4] = 32'h1001_0004; e_we[4] = 1'b0; e_in[4] = SZ_WORD; e_out[4] = 3'b111;
        e_addr[5] = 32'h1001_0004; e_we[5] = 1'b1; e_in[5] = 2'b11;   e_out[5] = LD_LW;
        e_addr[6] = 32'h1001_0006; e_we[6] = 1'b1; e_in[6] = SZ_WORD; e_out[6] = LD_LW;
        for (int i = 0; i < 7; i++) begin
            req0(e_we[i], e_in[i], e_out[i], e_addr[i], 32'h0, lat, dout, err);
            total++;
            if (lat !== 1 || err !== 1'b1 || dout !== 32'h0) begin
                bad++;
                $display("[TB] FAIL err_case%0d got=lat%0d_err%b_data%h want=lat1_err1_data00000000", i, lat, err, dout);
            end
        end
        req0(1'b0, SZ_WORD, LD_LW, 32'h1001_0004, 32'h0, lat, dout, err);
        total++; if (dout !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL err_no_write got=%h want=deadbeef", dout); end
        req0(1'b0, SZ_WORD, LD_LW, 32'h1001_1FFC, 32'h0, lat, dout, err);
        total++; if (lat !== 2 || err !== 1'b0) begin bad++; $display("[TB] FAIL last_word got=lat%0d_err%b want=lat2_err0", lat, err); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] dout; logic err;
        int guard; int pulses;
        logic exp_ready, exp_rv;
        req3(1'b1, SZ_WORD, LD_LW, 32'h1001_0020, 32'h0BAD_F00D, lat, dout, err);
        total++; if (lat !== 6) begin bad++; $display("[TB] FAIL ws3_sw_latency got=%0d want=6", lat); end
        @(negedge clk_in);
        bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.dmem_inchoice = SZ_WORD;
        bus3.dmem_outchoice = LD_LW; bus3.addr = 32'h1001_0020; bus3.data_in = 32'h0;
        guard = 0;
        while (bus3.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        total++;
        if (guard >= 50) begin
            bad++; $display("[TB] FAIL b2b_start got=ready_low want=ready_high");
            bus3.req_valid = 1'b0;
            return;
        end
        @(posedge clk_in);
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_in);
            exp_ready = (k == 6) || (k >= 12);
            exp_rv    = (k == 5) || (k == 11);
            total++;
            if (bus3.req_ready !== exp_ready) begin
                bad++; $display("[TB] FAIL b2b_ready_c%0d got=%b want=%b", k, bus3.req_ready, exp_ready);
            end
            total++;
            if (bus3.resp_valid !== exp_rv) begin
                bad++; $display("[TB] FAIL b2b_resp_valid_c%0d got=%b want=%b", k, bus3.resp_valid, exp_rv);
            end
            total++;
            if (bus3.data_out !== (exp_rv ? 32'h0BAD_F00D : 32'h0)) begin
                bad++; $display("[TB] FAIL b2b_data_c%0d got=%h want=%h", k, bus3.data_out, exp_rv ? 32'h0BAD_F00D : 32'h0);
            end
            if (bus3.resp_valid === 1'b1) pulses++;
            if (k == 11) bus3.req_valid = 1'b0;
        end
        total++; if (pulses !== 2) begin bad++; $display("[TB] FAIL b2b_pulses got=%0d want=2", pulses); end
    endtask

    task automatic test_reset_mid_store();
        int lat; logic [31:0] dout; logic err;
        int guard; int seen;
        req3(1'b1, SZ_WORD, LD_LW, 32'h1001_0030, 32'h0, lat, dout, err);
        @(negedge clk_in);
        bus3.req_valid = 1'b1; bus3.req_we = 1'b1; bus3.dmem_inchoice = SZ_WORD;
        bus3.dmem_outchoice = LD_LW; bus3.addr = 32'h1001_0030; bus3.data_in = 32'h1234_5678;
        guard = 0;
        while (bus3.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        total++;
        if (guard >= 50) begin
            bad++; $display("[TB] FAIL mid_rst_start got=ready_low want=ready_high");
            bus3.req_valid = 1'b0;
            return;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        bus3.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk_in);
        total++; if (bus3.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_ready_in_reset got=%b want=0", bus3.req_ready); end
        reset = 1'b0;
        @(negedge clk_in);
        total++; if (bus3.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_ready_after got=%b want=1", bus3.req_ready); end
        seen = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (bus3.resp_valid !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL mid_rst_no_resp got=%0d want=0", seen); end
        req3(1'b0, SZ_WORD, LD_LW, 32'h1001_0030, 32'h0, lat, dout, err);
        total++; if (dout !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_dropped got=%h want=00000000", dout); end
        total++; if (lat !== 5) begin bad++; $display("[TB] FAIL ws3_lw_latency got=%0d want=5", lat); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.dmem_inchoice = 2'b00;
        bus0.dmem_outchoice = 3'b000; bus0.addr = 32'h0; bus0.data_in = 32'h0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.dmem_inchoice = 2'b00;
        bus3.dmem_outchoice = 3'b000; bus3.addr = 32'h0; bus3.data_in = 32'h0;
        test_reset();
        test_word();
        test_byte_lanes();
        test_half_lanes();
        test_errors();
        test_back_to_back();
        test_reset_mid_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
